// File: rtl/cond_inv_pkg.sv
// rtl/cond_inv_pkg.sv - mode encoding and the shared conditional-invert function
package cond_inv_pkg;

    // Widest operand the shared function handles; narrower callers zero-extend and slice.
    localparam int CI_MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_MASK = 2'b01,
        MODE_INV  = 2'b10,
        MODE_ZERO = 2'b11
    } mode_t;

    // Returns {cin, result}; cin is set only on the subtract path.
    function automatic logic [CI_MAX_W:0] cond_inv_f(
        input logic [CI_MAX_W-1:0] a,
        input logic [CI_MAX_W-1:0] b,
        input mode_t               mode
    );
        logic [CI_MAX_W:0] r;
        r = '0;
        unique case (mode)
            MODE_PASS: r = {1'b0, a};
            MODE_MASK: r = {1'b0, a ^ b};
            MODE_INV:  r = {1'b1, ~a};
            MODE_ZERO: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_inv_stage.sv
// rtl/cond_inv_stage.sv - one {valid, data, cin} pipeline register with load enable
module cond_inv_stage
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_d,
    input  logic [WIDTH-1:0] data_d,
    input  logic             cin_d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic             cin_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cin_q   <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cin_q   <= cin_d;
        end
    end

endmodule

// File: rtl/cond_inv_pipe.sv
// rtl/cond_inv_pipe.sv - pipelined conditional inverter with carry-in side-band and valid/ready flow control
module cond_inv_pipe
    import cond_inv_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
)
(
    input  logic             clkpos,
    input  logic             reset,
    input  logic             vdd,
    input  logic             vss,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cin_out,
    output logic             busy
);

    logic [CI_MAX_W:0] fr;
    logic              adv;
    logic              unused_supply;

    // Index 0 is the combinational operand-prep result; index k is stage k.
    logic [STAGES:0]   v;
    logic [STAGES:0]   c;
    logic [WIDTH-1:0]  d [0:STAGES];

    assign unused_supply = vdd ^ vss;

    assign fr   = cond_inv_f(CI_MAX_W'(a), CI_MAX_W'(b), mode_t'(mode));
    assign v[0] = in_valid;
    assign d[0] = fr[WIDTH-1:0];
    assign c[0] = fr[CI_MAX_W];

    if (WIDTH < CI_MAX_W) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^fr[CI_MAX_W-1:WIDTH];
    end

    // Whole pipe moves or whole pipe holds; bubbles are never squeezed out.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        cond_inv_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clkpos),
            .rst     (reset),
            .en      (adv),
            .valid_d (v[k-1]),
            .data_d  (d[k-1]),
            .cin_d   (c[k-1]),
            .valid_q (v[k]),
            .data_q  (d[k]),
            .cin_q   (c[k])
        );
    end

    assign out_valid = v[STAGES];
    assign out       = d[STAGES];
    assign cin_out   = c[STAGES];
    assign busy      = |v[STAGES:1];

endmodule

// File: doc/cond_inv_pipe.md
Name: cond_inv_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-bit conditional inverter used in the ALU operand path.
- Conditionally inverts operand A, either per bit under mask B or per word under a mode field, and emits the matching carry-in for two's-complement subtraction.
- Carries data through a STAGES-deep register pipeline with valid/ready flow control, so the operand-prep stage can be retimed against the adder without changing the interface.

Parameters:
- WIDTH, 16, operand width in bits (>=1)
- STAGES, 2, pipeline depth in clock cycles (>=1)

Ports:
- clkpos  input  1  single pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- vdd  input  1  supply pin, kept for netlist compatibility; no RTL function
- vss  input  1  supply pin, kept for netlist compatibility; no RTL function
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts the word this cycle
- a  input  WIDTH  operand
- b  input  WIDTH  per-bit invert mask
- mode  input  2  operation select, see Behaviour
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out  output  WIDTH  conditionally inverted operand
- cin_out  output  1  carry-in for the downstream adder
- busy  output  1  any stage holds a valid word

Behaviour:
- Reset is asynchronous and active-high. It is fixed and applies to all registers immediately.
  - All stage valid bits = 0; all data and cin registers = 0.
  - Outputs during/after reset: out = 0, cin_out = 0, out_valid = 0, busy = 0, in_ready = 1.
- Mode encoding (input side, combinational into stage 1). Packaged constants MODE_PASS, MODE_MASK, MODE_INV, MODE_ZERO.
  - 00 PASS: result = a, cin = 0.
  - 01 MASK: result = a ^ b (bitwise; b[i]=1 inverts a[i]), cin = 0.
  - 10 INV: result = ~a, cin = 1 (subtract path).
  - 11 ZERO: result = 0, cin = 0; a and b are ignored.
- Pipeline: STAGES registers, each holding {valid, data[WIDTH], cin}. Stage 1 captures the computed result; stage k captures stage k-1. out, cin_out and out_valid are driven directly from the last stage.
- Advance condition: adv = out_ready | ~out_valid. Computed combinationally; it is the only combinational path from an output-side input.
  - When adv = 1, every stage shifts by one. Stage 1 loads in_valid and the new result.
  - When adv = 0, every stage holds; no bubble collapsing.
  - in_ready = adv.
  - Handshakes complete when in_valid & in_ready (input side) and out_valid & out_ready (output side).
- Latency:
  - A word accepted at edge n appears at out with out_valid = 1 after edge n+STAGES-1, provided adv stayed high.
  - With STAGES = 1, the result is visible in the cycle after acceptance.
- Throughput: one word per cycle while out_ready = 1.
- Stall rules:
  - While out_valid & ~out_ready, out and cin_out are held stable and in_ready = 0.
  - A word presented with in_valid = 1 and in_ready = 0 is not consumed; the source must hold it.
- Bubbles: a cycle with adv = 1 and in_valid = 0 inserts valid = 0 at stage 1. When valid = 0, data/cin content at a stage is don't-care, but the bench checks out only when out_valid = 1.
- Simultaneous accept and emit in the same cycle is legal and is the steady state.
- Reset mid-stream discards every in-flight word; no output handshake occurs for them.
- busy = OR of all stage valid bits.
- Width rules: all operations are bitwise, with no carry propagation inside the block. cin_out is the only arithmetic side-band.

Decomposition:
- Package cond_inv_pkg:
  - mode_t (2-bit enum) with the four MODE_* constants.
  - A function cond_inv_f(a, b, mode), returning {cin, result}; shared with the ALU reference model.
- One natural sub-module, cond_inv_stage: a single {valid, data, cin} register with an enable and async reset.
  - Instantiated STAGES times via a generate loop.
  - The top level holds the mode decode and the adv/ready logic.

Test Plan:
- Reset then idle, WIDTH=16, STAGES=2 -> out=0, cin_out=0, out_valid=0, in_ready=1, busy=0. Asserting reset asynchronously mid-clock clears a held word at once.
- Streaming, out_ready=1:
  - a=16'h00F0, b=16'h0FF0, MASK -> out=16'h0F00, cin_out=0.
  - Next cycle, a=16'h1234, INV -> out=16'hEDCB, cin_out=1.
  - Results arrive on consecutive cycles, 2 cycles after each accept.
- ZERO and PASS back-to-back:
  - a=16'hFFFF, ZERO -> out=0.
  - a=16'hA5A5, PASS -> out=16'hA5A5.
  - No bubble between them.
- Backpressure:
  - Hold out_ready=0 for 3 cycles while valid data sits at the output -> out stable, in_ready=0, the pending input is not consumed.
  - Release -> the words emerge in order with no loss or duplication.
- Bubble and occupancy:
  - in_valid pattern 1,0,1 with out_ready=1 -> out_valid pattern 1,0,1 delayed by STAGES.
  - busy deasserts the cycle after the last word leaves.
- Parameter sweep: WIDTH=1/STAGES=1 and WIDTH=32/STAGES=4 with random a, b, mode and random out_ready -> scoreboard matches cond_inv_f for every completed output handshake.
